// File: rtl/steer_en_fsm.sv
// Rider-presence / steering-enable controller.
// Latches left/right load-cell pairs, checks that total weight and balance
// are acceptable, and only enables steering once the rider has stood
// balanced for a full settle-timer period.
//
// Handshake: ld_vld is a one-cycle strobe with no back-pressure; the
// lft_ld/rght_ld pair is taken on any clock where ld_vld is high and
// is held until the next strobe.
module steer_en_fsm #(
    parameter logic        FAST_SIM     = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic        tmr_full
);

    localparam int TMR_W = FAST_SIM ? 15 : 26;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] STEER = 2'd2;

    // Thresholds carried in 13 bits so they compare directly with sum.
    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [11:0]      lft_r;
    logic [11:0]      rght_r;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;

    logic [12:0] sum;
    logic [11:0] adiff;
    logic        sum_gt;
    logic        sum_lt;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    // Weight and balance flags, all derived from the latched sample pair.
    always_comb begin
        sum           = {1'b0, lft_r} + {1'b0, rght_r};
        adiff         = (lft_r >= rght_r) ? (lft_r - rght_r) : (rght_r - lft_r);
        sum_gt        = sum > THR_HI;
        sum_lt        = sum < THR_LO;
        diff_gt_1_4   = {1'b0, adiff} > {2'b00, sum[12:2]};
        diff_gt_15_16 = {1'b0, adiff} > (sum - {4'b0000, sum[12:4]});
    end

    assign tmr_full = &timer;

    // Next-state decision; the settle timer only runs while staying in WAIT
    // with acceptable balance and reads zero everywhere else.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        case (state)
            IDLE: begin
                if (sum_gt) state_nxt = WAIT;
            end
            WAIT: begin
                if (sum_lt) begin
                    state_nxt = IDLE;
                end else if (diff_gt_1_4) begin
                    state_nxt = WAIT;
                end else if (tmr_full) begin
                    state_nxt = STEER;
                end else begin
                    state_nxt = WAIT;
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            STEER: begin
                if (sum_lt) begin
                    state_nxt = IDLE;
                end else if (diff_gt_15_16) begin
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Keeps the timer pinned at all-ones should it ever be full while
        // remaining in WAIT; it must never wrap back to zero.
        if (state == WAIT && state_nxt == WAIT && !diff_gt_1_4 && tmr_full) begin
            timer_nxt = timer;
        end
    end

    // State, timer, sample latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            lft_r     <= '0;
            rght_r    <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            en_steer  <= (state_nxt == STEER);
            rider_off <= (state_nxt == IDLE);
            if (ld_vld) begin
                lft_r  <= lft_ld;
                rght_r <= rght_ld;
            end
        end
    end

endmodule

// File: tb/tb_steer_en_fsm.sv
// Self-checking bench for steer_en_fsm (FAST_SIM=1, 15-bit settle timer).
// A behavioural model of the rider rules runs in lockstep with the DUT.
module tb_steer_en_fsm;

    logic        clk;
    logic        rst;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;
    logic        tmr_full;

    int n_vec;
    int n_err;

    // Model: last accepted sample, rider mode and settle count.
    int m_l;
    int m_r;
    int m_mode;   // 0 = no rider, 1 = settling, 2 = steering
    int m_cnt;
    localparam int SETTLE_MAX = 32767;

    steer_en_fsm #(.FAST_SIM(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .tmr_full  (tmr_full)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference rules evaluated once per clock edge.
    task automatic model_step(input logic r_i, input logic v_i, input int l, input int r);
        int sum;
        int ad;
        if (r_i) begin
            m_mode = 0; m_cnt = 0; m_l = 0; m_r = 0;
            return;
        end
        sum = m_l + m_r;
        ad  = (m_l > m_r) ? m_l - m_r : m_r - m_l;
        if (m_mode == 0) begin
            if (sum > 'h240) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (sum < 'h1C0) begin m_mode = 0; m_cnt = 0; end
            else if (ad > sum / 4) m_cnt = 0;
            else if (m_cnt == SETTLE_MAX) begin m_mode = 2; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end else begin
            if (sum < 'h1C0) m_mode = 0;
            else if (ad > sum - sum / 16) begin m_mode = 1; m_cnt = 0; end
        end
        if (v_i) begin m_l = l; m_r = r; end
    endtask

    // Driver: apply one cycle of inputs, advance the model, settle past the edge.
    task automatic tick(input logic r_i, input logic v_i, input int l, input int r);
        rst     = r_i;
        ld_vld  = v_i;
        lft_ld  = 12'(l);
        rght_ld = 12'(r);
        @(posedge clk);
        model_step(r_i, v_i, l, r);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 'h300, 'h300);
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1 || tmr_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset: en=%b off=%b full=%b, want en=0 off=1 full=0", en_steer, rider_off, tmr_full);
        end
        tick(1'b0, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 0, 0);
        n_vec++;
        if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
            n_err++;
            $display("FAIL reset_load_cleared: en=%b off=%b, want en=0 off=1", en_steer, rider_off);
        end
    endtask

    task automatic test_balanced();
        int n;
        tick(1'b0, 1'b1, 'h180, 'h180);
        n_vec++;
        if (rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL balanced_latency: off=%b, want 1", rider_off);
        end
        n = 0;
        do begin
            tick(1'b0, 1'b0, 0, 0);
            n++;
            if (n == 1) begin
                n_vec++;
                if (rider_off !== 1'b0 || en_steer !== 1'b0) begin
                    n_err++;
                    $display("FAIL balanced_wait: en=%b off=%b, want en=0 off=0", en_steer, rider_off);
                end
            end
        end while (en_steer !== 1'b1 && n < 40000);
        n_vec++;
        if (n != 32769) begin
            n_err++;
            $display("FAIL balanced_settle: en_steer after %0d clk, want 32769", n);
        end
    endtask

    task automatic test_steer_hold();
        tick(1'b0, 1'b1, 'h2A0, 'h060);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 0, 0);
        n_vec++;
        if (en_steer !== 1'b1 || rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL steer_within_15_16: en=%b off=%b, want en=1 off=0", en_steer, rider_off);
        end
        tick(1'b0, 1'b1, 'h0E8, 'h0E8);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 0, 0);
        n_vec++;
        if (en_steer !== 1'b1) begin
            n_err++;
            $display("FAIL steer_hyst_band: en=%b, want 1", en_steer);
        end
    endtask

    task automatic test_diff_trip();
        tick(1'b0, 1'b1, 'h2F0, 'h010);
        n_vec++;
        if (en_steer !== 1'b1) begin
            n_err++;
            $display("FAIL trip_old_sample: en=%b, want 1", en_steer);
        end
        tick(1'b0, 1'b0, 0, 0);
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0 || tmr_full !== 1'b0) begin
            n_err++;
            $display("FAIL trip_to_wait: en=%b off=%b full=%b, want 0 0 0", en_steer, rider_off, tmr_full);
        end
    endtask

    task automatic test_unbalanced();
        int n;
        int bad;
        tick(1'b0, 1'b1, 'h280, 'h080);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b0, 0, 0);
            if (tmr_full !== 1'b0 || en_steer !== 1'b0 || rider_off !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL unbalanced_hold: %0d bad cycles, want 0", bad);
        end
        tick(1'b0, 1'b1, 'h180, 'h180);
        n = 0;
        do begin
            tick(1'b0, 1'b0, 0, 0);
            n++;
            if (n == 32767) begin
                n_vec++;
                if (tmr_full !== 1'b1 || en_steer !== 1'b0) begin
                    n_err++;
                    $display("FAIL timer_full_edge: full=%b en=%b, want full=1 en=0", tmr_full, en_steer);
                end
            end
        end while (en_steer !== 1'b1 && n < 40000);
        n_vec++;
        if (n != 32768) begin
            n_err++;
            $display("FAIL rebalance_settle: en_steer after %0d clk, want 32768", n);
        end
    endtask

    task automatic test_rst_mid_steer();
        int bad;
        tick(1'b1, 1'b0, 0, 0);
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_steer: en=%b off=%b, want en=0 off=1", en_steer, rider_off);
        end
        tick(1'b0, 1'b1, 'h180, 'h180);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            tick(1'b0, 1'b0, 0, 0);
            if (en_steer !== 1'b0 || tmr_full !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0 || rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL requalify: %0d early cycles, off=%b, want 0 cycles off=0", bad, rider_off);
        end
    endtask

    task automatic test_hysteresis();
        int pts_l[5] = '{'h0E8, 'h0E0, 'h0E0, 'h120, 'h121};
        int pts_r[5] = '{'h0E8, 'h0E0, 'h0DF, 'h120, 'h120};
        logic exp_off[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, pts_l[k], pts_r[k]);
            tick(1'b0, 1'b0, 0, 0);
            tick(1'b0, 1'b0, 0, 0);
            n_vec++;
            if (rider_off !== exp_off[k] || en_steer !== 1'b0) begin
                n_err++;
                $display("FAIL hyst_%0d: sum=%0h off=%b en=%b, want off=%b en=0",
                         k, pts_l[k] + pts_r[k], rider_off, en_steer, exp_off[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b1, 0, 0);
        tick(1'b0, 1'b0, 0, 0);
        tick(1'b0, 1'b1, 'h180, 'h180);
        tick(1'b0, 1'b1, 0, 0);
        n_vec++;
        if (rider_off !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: off=%b, want 0", rider_off);
        end
        tick(1'b0, 1'b0, 0, 0);
        n_vec++;
        if (rider_off !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: off=%b, want 1", rider_off);
        end
    endtask

    task automatic test_random();
        int l;
        int r;
        for (int i = 0; i < 3000; i++) begin
            l = (($urandom_range(0, 15)) == 0) ? 'hFFF : $urandom_range(0, 'h200);
            r = (($urandom_range(0, 15)) == 0) ? 'hFFF : $urandom_range(0, 'h200);
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, l, r);
            n_vec++;
            if (en_steer !== (m_mode == 2) || rider_off !== (m_mode == 0) ||
                tmr_full !== (m_cnt == SETTLE_MAX)) begin
                n_err++;
                $display("FAIL random_%0d: en=%b off=%b full=%b, want en=%b off=%b full=%b",
                         i, en_steer, rider_off, tmr_full,
                         m_mode == 2, m_mode == 0, m_cnt == SETTLE_MAX);
            end
        end
    endtask

    // Sequence of scenarios and final report.
    initial begin
        n_vec = 0; n_err = 0;
        m_l = 0; m_r = 0; m_mode = 0; m_cnt = 0;
        rst = 1'b1; ld_vld = 1'b0; lft_ld = '0; rght_ld = '0;
        test_reset();
        test_balanced();
        test_steer_hold();
        test_diff_trip();
        test_unbalanced();
        test_rst_mid_steer();
        test_hysteresis();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
